// File: rtl/mtf_decoder.sv
// mtf_decoder: move-to-front decoder.
// Rebuilds data words from a stream of literal / index tokens while keeping a
// recency list that tracks the encoder's list (entry 0 = most recent).
//
// Ports
//   clk_in, rst_n_in               clock, async active-low reset
//   tok_valid_in / tok_ready_out   token handshake
//   tok_hit_in                     1 = index token, 0 = literal token
//   tok_idx_in                     list index (hit tokens)
//   tok_lit_in                     literal value (literal tokens)
//   data_out / out_valid_out / out_ready_in   decoded word handshake
//   err_out                        one-cycle pulse: hit on an invalid entry
//   list_out                       entry i at [i*WIDTH +: WIDTH]
//   list_valid_out                 per-entry valid bits

// One list entry: loads d when ld is asserted.
module mtf_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) q <= '0;
    else if (ld)   q <= d;
endmodule

module mtf_decoder #(
  parameter  int WIDTH = 8,
  parameter  int NUM   = 4,
  localparam int IDXW  = $clog2(NUM)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 tok_valid_in,
  output logic                 tok_ready_out,
  input  logic                 tok_hit_in,
  input  logic [IDXW-1:0]      tok_idx_in,
  input  logic [WIDTH-1:0]     tok_lit_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 out_valid_out,
  input  logic                 out_ready_in,
  output logic                 err_out,
  output logic [NUM*WIDTH-1:0] list_out,
  output logic [NUM-1:0]       list_valid_out
);

  logic [NUM-1:0][WIDTH-1:0] ent, ent_d;
  logic [NUM-1:0]            shift;
  logic [WIDTH-1:0]          hit_val, head;
  logic                      hit_vld, accept, lit, hit_ok, hit_bad;

  assign tok_ready_out = !out_valid_out || out_ready_in;
  assign accept        = tok_valid_in && tok_ready_out;

  // Index lookup. An index beyond NUM-1 matches no entry, so it reads as
  // invalid and falls into the error path without a separate range check.
  always_comb begin
    hit_val = '0;
    hit_vld = 1'b0;
    for (int i = 0; i < NUM; i++)
      if (tok_idx_in == IDXW'(i)) begin
        hit_val = ent[i];
        hit_vld = list_valid_out[i];
      end
  end

  assign lit     = !tok_hit_in;
  assign hit_ok  = tok_hit_in && hit_vld;
  assign hit_bad = tok_hit_in && !hit_vld;
  assign head    = lit ? tok_lit_in : hit_val;

  // Literal shifts the whole list; a hit shifts entries 0..k only, and the
  // hit value lands at the front. A k=0 hit reloads entry 0 with itself.
  always_comb begin
    ent_d[0] = head;
    for (int j = 1; j < NUM; j++) ent_d[j] = ent[j-1];
    for (int j = 0; j < NUM; j++)
      shift[j] = accept && (lit || (hit_ok && (int'(tok_idx_in) >= j)));
  end

  for (genvar g = 0; g < NUM; g++) begin : g_slot
    mtf_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_in  (clk_in),
      .rst_n_in(rst_n_in),
      .ld      (shift[g]),
      .d       (ent_d[g]),
      .q       (ent[g])
    );
  end

  assign list_out = ent;

  // Valid bits always form a contiguous prefix; only literals grow it.
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in)          list_valid_out <= '0;
    else if (accept && lit) list_valid_out <= {list_valid_out[NUM-2:0], 1'b1};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_out      <= '0;
      out_valid_out <= 1'b0;
      err_out       <= 1'b0;
    end else begin
      err_out <= accept && hit_bad;
      if (accept) begin
        data_out      <= hit_bad ? '0 : head;
        out_valid_out <= 1'b1;
      end else if (out_ready_in) begin
        out_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtf_decoder.sv
module tb_mtf_decoder;
  localparam int WIDTH = 8;
  localparam int NUM   = 4;

  logic                 clk_in = 0, rst_n_in = 0;
  logic                 tok_valid_in = 0, tok_hit_in = 0, out_ready_in = 0;
  logic [1:0]           tok_idx_in = '0;
  logic [WIDTH-1:0]     tok_lit_in = '0;
  logic                 tok_ready_out, out_valid_out, err_out;
  logic [WIDTH-1:0]     data_out;
  logic [NUM*WIDTH-1:0] list_out;
  logic [NUM-1:0]       list_valid_out;

  mtf_decoder #(.WIDTH(WIDTH), .NUM(NUM)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .tok_valid_in(tok_valid_in), .tok_ready_out(tok_ready_out),
    .tok_hit_in(tok_hit_in), .tok_idx_in(tok_idx_in), .tok_lit_in(tok_lit_in),
    .data_out(data_out), .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .err_out(err_out), .list_out(list_out), .list_valid_out(list_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0, bad = 0;

  // Reference model: recency list as a queue, front = most recent.
  int q[$];
  int m_data = 0;
  bit m_ov = 0, m_err = 0;

  function automatic logic [63:0] m_list();
    logic [63:0] r = '0;
    for (int i = 0; i < q.size(); i++) r[i*WIDTH +: WIDTH] = q[i][WIDTH-1:0];
    return r;
  endfunction

  function automatic logic [63:0] m_vld();
    return (64'd1 << q.size()) - 64'd1;
  endfunction

  function automatic bit in_list(int v);
    foreach (q[i]) if (q[i] == v) return 1;
    return 0;
  endfunction

  task automatic m_clear();
    q.delete();
    m_data = 0; m_ov = 0; m_err = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"}, 64'(data_out), 64'(m_data));
    chk({tag, ".ov"},   64'(out_valid_out), 64'(m_ov));
    chk({tag, ".err"},  64'(err_out), 64'(m_err));
    chk({tag, ".list"}, 64'(list_out), m_list());
    chk({tag, ".lv"},   64'(list_valid_out), m_vld());
  endtask

  // One clock cycle: drive a token, check ready, step, update model, check.
  task automatic cyc(input bit v, input bit h, input int idx, input int lit,
                     input bit ordy, input string tag);
    bit acc, exp_rdy;
    tok_valid_in = v; tok_hit_in = h; tok_idx_in = idx[1:0];
    tok_lit_in = lit[WIDTH-1:0]; out_ready_in = ordy;
    #1;
    exp_rdy = !m_ov || ordy;
    chk({tag, ".rdy"}, 64'(tok_ready_out), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk_in); #1;
    m_err = 0;
    if (acc) begin
      m_ov = 1;
      if (!h) begin
        q.push_front(lit);
        if (q.size() > NUM) void'(q.pop_back());
        m_data = lit;
      end else if (idx < q.size()) begin
        int val = q[idx];
        q.delete(idx);
        q.push_front(val);
        m_data = val;
      end else begin
        m_data = 0;
        m_err  = 1;
      end
    end else if (ordy) m_ov = 0;
    chk_all(tag);
  endtask

  task automatic do_reset();
    rst_n_in = 0; tok_valid_in = 0; out_ready_in = 1;
    #12;
    m_clear();
    chk_all("reset");
    @(negedge clk_in); rst_n_in = 1;
    @(posedge clk_in); #1;
  endtask

  initial begin
    do_reset();

    // Literals 1,2,3 then hits / eviction sequence from the plan.
    cyc(1, 0, 0, 1, 1, "lit1");
    chk("plan.d1", 64'(data_out), 64'd1);
    cyc(1, 0, 0, 2, 1, "lit2");
    cyc(1, 0, 0, 3, 1, "lit3");
    chk("plan.l123", 64'(list_out), 64'h00010203);
    chk("plan.v123", 64'(list_valid_out), 64'b0111);
    cyc(1, 1, 2, 0, 1, "hit2");
    chk("plan.dh2", 64'(data_out), 64'd1);
    chk("plan.lh2", 64'(list_out), 64'h00020301);
    cyc(1, 0, 0, 4, 1, "lit4");
    chk("plan.l4", 64'(list_out), 64'h02030104);
    chk("plan.v4", 64'(list_valid_out), 64'b1111);
    cyc(1, 0, 0, 5, 1, "lit5");
    chk("plan.l5", 64'(list_out), 64'h03010405);
    cyc(1, 1, 0, 0, 1, "hit0");
    chk("plan.dh0", 64'(data_out), 64'd5);
    chk("plan.lh0", 64'(list_out), 64'h03010405);
    cyc(1, 1, 3, 0, 1, "hit3");
    chk("plan.dh3", 64'(data_out), 64'd3);
    chk("plan.lh3", 64'(list_out), 64'h01040503);

    // Backpressure: token waits 3 cycles, then goes through exactly once.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 9, 0, "bp_hold");
    chk("plan.bp_rdy", 64'(tok_ready_out), 64'd0);
    chk("plan.bp_data", 64'(data_out), 64'd3);
    cyc(1, 0, 0, 9, 1, "bp_rel");
    chk("plan.bp_new", 64'(data_out), 64'd9);
    cyc(0, 0, 0, 0, 1, "bp_idle");
    chk("plan.bp_list", 64'(list_out), 64'h04050309);

    // Hit on an empty list -> error pulse.
    do_reset();
    cyc(1, 1, 1, 0, 1, "err_hit");
    chk("plan.err", 64'(err_out), 64'd1);
    chk("plan.err_lv", 64'(list_valid_out), 64'd0);
    cyc(0, 0, 0, 0, 1, "err_after");
    chk("plan.err_clr", 64'(err_out), 64'd0);

    // Build [4,1,3,2], then async reset between edges.
    cyc(1, 0, 0, 2, 1, "b2");
    cyc(1, 0, 0, 3, 1, "b3");
    cyc(1, 0, 0, 1, 1, "b1");
    cyc(1, 0, 0, 4, 1, "b4");
    chk("plan.pre_rst", 64'(list_out), 64'h02030104);
    #3 rst_n_in = 0;
    #1;
    m_clear();
    chk_all("async_rst");
    chk("async_rst.rdy", 64'(tok_ready_out), 64'd1);
    @(negedge clk_in); rst_n_in = 1;
    cyc(1, 0, 0, 7, 1, "post_rst");
    chk("plan.l7", 64'(list_out), 64'h00000007);
    chk("plan.v7", 64'(list_valid_out), 64'b0001);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit v, h, r;
      int idx, lit;
      v   = ($urandom_range(0, 3) != 0);
      h   = $urandom_range(0, 1);
      r   = ($urandom_range(0, 9) < 7);
      idx = $urandom_range(0, NUM - 1);
      do lit = $urandom_range(0, 255); while (in_list(lit));
      cyc(v, h, idx, lit, r, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
